// File: rtl/ga_trace_buffer.sv
// ga_trace_buffer: records {best_fit, best} once per GA generation, then
// streams the history out in generation order on a valid/ready interface.
module ga_trace_buffer #(
  parameter int unsigned CHROM_W = 8,
  parameter int unsigned FIT_W   = 27,
  parameter int unsigned DEPTH   = 100,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned DATA_W = FIT_W + CHROM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_strobe,
  input  logic [CHROM_W-1:0] best,
  input  logic [FIT_W-1:0]   best_fit,
  input  logic              finished,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                mem_we;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign wr_data = {best_fit, best};

  // State and registered outputs/pointers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CAPTURE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
    end
  end

  // History storage; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Next-state logic: CAPTURE -> DRAIN -> DONE, DONE holds until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CAPTURE: begin
        if (finished) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          state_d = ST_DONE;
        end else if (out_valid_q && out_ready && out_last_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_CAPTURE;
    endcase
  end

  // Datapath/output next values
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = done_q;
    out_data_d  = out_data_q;
    mem_we      = 1'b0;
    case (state_q)
      ST_CAPTURE: begin
        if (gen_strobe) begin
          if (count_q < CNT_W'(DEPTH)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
            count_d  = count_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Present entry 0 on the first DRAIN cycle; bypass a same-cycle write to it
        if (finished) begin
          rd_ptr_d    = '0;
          out_valid_d = (count_d != '0);
          out_last_d  = (count_d == CNT_W'(1));
          if (count_d != '0) begin
            out_data_d = (mem_we && (wr_ptr_q == '0)) ? wr_data : mem_q[0];
          end
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) begin
          done_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            rd_ptr_d   = rd_ptr_q + CNT_W'(1);
            out_data_d = mem_q[rd_ptr_d];
            out_last_d = (rd_ptr_d == count_q - CNT_W'(1));
          end
        end
      end
      ST_DONE: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        done_d      = 1'b1;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ga_trace_buffer.sv
// Directed bench for ga_trace_buffer: capture, drain with stalls, overflow,
// empty drain, same-cycle strobe/finished and mid-drain reset.
module tb_ga_trace_buffer;

  localparam int unsigned CHROM_W = 8;
  localparam int unsigned FIT_W   = 27;
  localparam int unsigned DEPTH   = 100;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned DATA_W  = FIT_W + CHROM_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               gen_strobe;
  logic [CHROM_W-1:0] best;
  logic [FIT_W-1:0]   best_fit;
  logic               finished;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];

  ga_trace_buffer #(.CHROM_W(CHROM_W), .FIT_W(FIT_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .gen_strobe (gen_strobe),
    .best       (best),
    .best_fit   (best_fit),
    .finished   (finished),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .count      (count),
    .overflow   (overflow),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; gen_strobe = 1'b0; finished = 1'b0; out_ready = 1'b0;
    best = '0; best_fit = '0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic strobe(input int b, input int f);
    @(negedge clk);
    gen_strobe = 1'b1;
    best       = CHROM_W'(b);
    best_fit   = FIT_W'(f);
    @(negedge clk);
    gen_strobe = 1'b0;
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0,1,0,0...
  // full=1: expect the whole queue then check DONE outputs
  task automatic drain(input int mode, input int n_beats, input bit full);
    int beats = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] held;
    logic held_last;
    held = '0; held_last = 1'b0;
    while (beats < n_beats && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      gen_strobe = 1'b0;
      out_ready  = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
      if (stalled) begin
        check("stall_data", 64'(out_data), 64'(held));
        check("stall_last", 64'(out_last), 64'(held_last));
      end
      stalled = 1'b0;
      if (out_valid) begin
        check("beat_data", 64'(out_data), 64'(exp_q[beats]));
        check("beat_last", 64'(out_last), 64'(beats == exp_q.size() - 1));
        if (out_ready) beats++;
        else begin
          stalled = 1'b1; held = out_data; held_last = out_last;
        end
      end
    end
    if (beats < n_beats) check("drain_timeout", 64'(beats), 64'(n_beats));
    if (full) begin
      @(negedge clk);
      out_ready = 1'b0;
      check("end_valid", 64'(out_valid), 64'd0);
      check("end_last", 64'(out_last), 64'd0);
      check("end_done", 64'(done), 64'd1);
    end
  endtask

  initial begin
    reset = 1'b1; gen_strobe = 1'b0; finished = 1'b0; out_ready = 1'b0;
    best = '0; best_fit = '0;

    // Reset state
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);

    // 1: full buffer, ready=1
    for (int i = 0; i < 100; i++) begin
      strobe(i, 1000 + i);
      exp_q.push_back({FIT_W'(1000 + i), CHROM_W'(i)});
    end
    check("t1_count", 64'(count), 64'd100);
    @(negedge clk); finished = 1'b1;
    drain(0, 100, 1'b1);
    check("t1_ovf", 64'(overflow), 64'd0);
    check("t1_count_hold", 64'(count), 64'd100);

    // 2: three entries with stalls
    do_reset();
    strobe(5, 50);  exp_q.push_back({FIT_W'(50), CHROM_W'(5)});
    strobe(9, 90);  exp_q.push_back({FIT_W'(90), CHROM_W'(9)});
    strobe(12, 120); exp_q.push_back({FIT_W'(120), CHROM_W'(12)});
    @(negedge clk); finished = 1'b1;
    drain(1, 3, 1'b1);

    // 3: overflow, 102 strobes
    do_reset();
    for (int i = 0; i < 102; i++) begin
      strobe(i, 2000 + i);
      if (i < 100) exp_q.push_back({FIT_W'(2000 + i), CHROM_W'(i)});
    end
    check("t3_count", 64'(count), 64'd100);
    check("t3_ovf", 64'(overflow), 64'd1);
    @(negedge clk); finished = 1'b1;
    drain(0, 100, 1'b1);
    check("t3_ovf_hold", 64'(overflow), 64'd1);

    // 4: finished with no strobes
    do_reset();
    @(negedge clk); finished = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("t4_valid1", 64'(out_valid), 64'd0);
    check("t4_done1", 64'(done), 64'd0);
    @(negedge clk);
    check("t4_valid2", 64'(out_valid), 64'd0);
    check("t4_done2", 64'(done), 64'd1);

    // 5: strobe in the same cycle finished rises
    do_reset();
    strobe(3, 30); exp_q.push_back({FIT_W'(30), CHROM_W'(3)});
    @(negedge clk);
    gen_strobe = 1'b1; best = 8'd77; best_fit = FIT_W'(770); finished = 1'b1;
    exp_q.push_back({FIT_W'(770), CHROM_W'(77)});
    drain(0, 2, 1'b1);
    check("t5_count", 64'(count), 64'd2);

    // 6: reset after 2 of 5 beats, then fresh capture from entry 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      strobe(20 + i, 200 + i);
      exp_q.push_back({FIT_W'(200 + i), CHROM_W'(20 + i)});
    end
    @(negedge clk); finished = 1'b1;
    drain(0, 2, 1'b0);
    @(negedge clk);
    reset = 1'b1; finished = 1'b0;
    @(negedge clk);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    reset = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    strobe(41, 4100); exp_q.push_back({FIT_W'(4100), CHROM_W'(41)});
    check("t6_recount", 64'(count), 64'd1);
    @(negedge clk); finished = 1'b1;
    drain(0, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
